crop_scheduler: RTL and testbench

CROP_SCHEDULER -- requirements
Module: crop_scheduler

---
 rtl/crop_scheduler.sv | 177 +++++++++++++++++
 tb/tb_crop_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_scheduler.sv
// crop_scheduler: queues crop-window requests and, one frame per request,
// streams a raster-order input frame while forwarding only the pixels that
// fall inside the requested window through a single output register.
module crop_scheduler #(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int IN_ROWS         = 9,
  parameter int IN_COLS         = 9,
  parameter int OUT_ROWS        = 3,
  parameter int OUT_COLS        = 3,
  parameter int QUEUE_DEPTH     = 4,
  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1,
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [RW-1:0]              cfg_y1,
  input  logic [CW-1:0]              cfg_x1,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_last,
  output logic [7:0]                 out_crop_id,
  output logic                       err_bad_cfg,
  output logic                       busy
);

  localparam int AW = $clog2(QUEUE_DEPTH);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                       r_state, w_state_next;
  logic [RW+CW-1:0]             r_q_mem [QUEUE_DEPTH];
  logic [AW-1:0]                r_wr_ptr, r_rd_ptr;
  logic [AW:0]                  r_count;
  logic [RW-1:0]                r_y1, r_row;
  logic [CW-1:0]                r_x1, r_col;
  logic [7:0]                   r_frame_id;
  logic                         r_out_valid, r_out_last, r_err;
  logic [PIXEL_BIT_WIDTH-1:0]   r_pixel_out;
  logic [7:0]                   r_out_crop_id;

  logic w_full, w_empty, w_cfg_fire, w_cfg_ok, w_push, w_pop;
  logic w_in_ready, w_accept, w_last_pix, w_in_win, w_win_last;

  // Request queue status and request validation (window must fit the frame).
  assign w_full     = (r_count == (AW+1)'(QUEUE_DEPTH));
  assign w_empty    = (r_count == '0);
  assign cfg_ready  = !reset && !w_full;
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_cfg_ok   = (32'(cfg_y1) + 32'(OUT_ROWS) <= 32'(IN_ROWS)) &&
                      (32'(cfg_x1) + 32'(OUT_COLS) <= 32'(IN_COLS));
  assign w_push     = w_cfg_fire && w_cfg_ok;

  // Position of the pixel currently offered, relative to the latched window.
  assign w_accept   = w_in_ready && in_valid;
  assign w_last_pix = (r_row == RW'(IN_ROWS - 1)) && (r_col == CW'(IN_COLS - 1));
  assign w_in_win   = (32'(r_row) >= 32'(r_y1)) &&
                      (32'(r_row) <  32'(r_y1) + 32'(OUT_ROWS)) &&
                      (32'(r_col) >= 32'(r_x1)) &&
                      (32'(r_col) <  32'(r_x1) + 32'(OUT_COLS));
  assign w_win_last = (32'(r_row) == 32'(r_y1) + 32'(OUT_ROWS) - 32'd1) &&
                      (32'(r_col) == 32'(r_x1) + 32'(OUT_COLS) - 32'd1);

  // Next-state and handshake decode: IDLE pops a request, STREAM consumes a frame.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        w_in_ready = !r_out_valid || out_ready;
        if (w_in_ready && in_valid && w_last_pix) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Queue storage: written on an accepted, valid request.
  // NOTE: the storage array is not reset; only the pointers and count are,
  // which is enough to make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_q_mem[r_wr_ptr] <= {cfg_y1, cfg_x1};
  end

  // Queue pointers and occupancy; simultaneous push and pop both take effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame context: latch window on pop, then walk row/col per accepted pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y1       <= '0;
      r_x1       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_frame_id <= '0;
    end else if (w_pop) begin
      {r_y1, r_x1} <= r_q_mem[r_rd_ptr];
      r_row        <= '0;
      r_col        <= '0;
      r_frame_id   <= r_frame_id + 8'd1;
    end else if (w_accept) begin
      if (r_col == CW'(IN_COLS - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Output register: load on an in-window pixel, clear once downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_pixel_out   <= '0;
      r_out_crop_id <= '0;
    end else if (w_accept && w_in_win) begin
      r_out_valid   <= 1'b1;
      r_out_last    <= w_win_last;
      r_pixel_out   <= pixel_in;
      r_out_crop_id <= r_frame_id;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // One-cycle error pulse for a request whose window does not fit.
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_cfg_fire && !w_cfg_ok;
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign pixel_out   = r_pixel_out;
  assign out_crop_id = r_out_crop_id;
  assign err_bad_cfg = r_err;
  assign busy        = (r_state == S_STREAM);

endmodule

// File: tb/tb_crop_scheduler.sv
// Bench for crop_scheduler: table of crop requests with known first/last
// pixels, hand-written multi-cycle sequences, and randomized requests and
// handshakes compared against a window-scan reference model.
module tb_crop_scheduler;

  localparam int PW   = 8;
  localparam int IR   = 9;
  localparam int IC   = 9;
  localparam int OR_  = 3;
  localparam int OC   = 3;
  localparam int QD   = 4;
  localparam int NPIX = IR * IC;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid, cfg_ready;
  logic [3:0]    cfg_y1, cfg_x1;
  logic          in_valid, in_ready;
  logic [PW-1:0] pixel_in;
  logic          out_valid, out_ready;
  logic [PW-1:0] pixel_out;
  logic          out_last;
  logic [7:0]    out_crop_id;
  logic          err_bad_cfg, busy;

  crop_scheduler #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IR), .IN_COLS(IC),
    .OUT_ROWS(OR_), .OUT_COLS(OC), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_y1(cfg_y1), .cfg_x1(cfg_x1),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
    .out_last(out_last), .out_crop_id(out_crop_id),
    .err_bad_cfg(err_bad_cfg), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int pix; int last; int id; } out_t;
  typedef struct { int y1; int x1; int bad; int first_pix; int last_pix; } vec_t;

  out_t got[$];
  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   idx     = 0;
  int   exp_id  = 0;

  // Record every output handshake; sampled mid-cycle, completes at next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)
      got.push_back('{int'(pixel_out), int'(out_last), int'(out_crop_id)});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the whole frame and keep the pixels inside the window.
  function automatic void build_exp(input int y, input int x, input int id);
    exp_q.delete();
    for (int r = 0; r < IR; r++)
      for (int c = 0; c < IC; c++)
        if (r >= y && r < y + OR_ && c >= x && c < x + OC)
          exp_q.push_back('{(r * IC + c) % 256,
                            (r == y + OR_ - 1 && c == x + OC - 1) ? 1 : 0, id});
  endfunction

  task automatic compare_frame(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) begin
        check($sformatf("%s_pix%0d", tag, i),  got[i].pix,  exp_q[i].pix);
        check($sformatf("%s_last%0d", tag, i), got[i].last, exp_q[i].last);
        check($sformatf("%s_id%0d", tag, i),   got[i].id,   exp_q[i].id);
      end
    end
  endtask

  // Offer one request; returns 1ns after the handshake edge.
  task automatic push_req(input int y, input int x);
    int n = 0;
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_y1    = 4'(y);
    cfg_x1    = 4'(x);
    @(negedge clk);
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("cfg_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Feed pixels idx..max_pix-1; drain the output register after a full frame.
  task automatic feed_frame(input bit rnd, input int max_pix, input int budget);
    int cyc = 0;
    while (idx < max_pix && cyc < budget) begin
      @(posedge clk); #1;
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_in  = idx[7:0];
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (idx < max_pix) check("feed_timeout", idx, max_pix);
    if (max_pix == NPIX) begin
      out_ready = 1'b1;
      cyc = 0;
      while (out_valid && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (cyc >= 50) check("drain_timeout", cyc, 0);
    end
  endtask

  task automatic check_bad_req(input string tag);
    check({tag, "_err_pulse"}, err_bad_cfg, 1);
    @(posedge clk); #1;
    check({tag, "_err_clear"}, err_bad_cfg, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check({tag, "_busy"}, busy, 0);
    end
    check({tag, "_no_output"}, got.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_pixel_out"}, pixel_out, 0);
    check({tag, "_crop_id"}, out_crop_id, 0);
    check({tag, "_err"}, err_bad_cfg, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2, 2, 0, 20, 40};
    vecs[1] = '{6, 6, 0, 60, 80};
    vecs[2] = '{7, 0, 1, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 20};
    vecs[4] = '{0, 6, 0, 6, 26};
    vecs[5] = '{3, 7, 1, 0, 0};

    reset = 1'b1; cfg_valid = 1'b0; cfg_y1 = '0; cfg_x1 = '0;
    in_valid = 1'b0; pixel_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_cfg_ready", cfg_ready, 1);

    // Table-driven requests with full, unthrottled handshakes.
    foreach (vecs[k]) begin
      string tag = $sformatf("vec%0d", k);
      got.delete();
      push_req(vecs[k].y1, vecs[k].x1);
      if (vecs[k].bad != 0) begin
        check_bad_req(tag);
      end else begin
        check({tag, "_no_err"}, err_bad_cfg, 0);
        exp_id = (exp_id + 1) % 256;
        build_exp(vecs[k].y1, vecs[k].x1, exp_id);
        idx = 0;
        feed_frame(1'b0, NPIX, 2000);
        compare_frame(tag);
        if (got.size() > 0) begin
          check({tag, "_first"}, got[0].pix, vecs[k].first_pix);
          check({tag, "_final"}, got[got.size()-1].pix, vecs[k].last_pix);
        end
        check({tag, "_idle_after"}, busy, 0);
      end
    end

    // Backpressure: first window pixel must hold while out_ready is low.
    got.delete();
    exp_id = (exp_id + 1) % 256;
    build_exp(2, 2, exp_id);
    push_req(2, 2);
    idx = 0;
    out_ready = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 300) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        pixel_in = idx[7:0];
        @(negedge clk);
        if (in_valid && in_ready) idx++;
        n++;
      end
      if (n >= 300) check("hold_wait_timeout", n, 0);
    end
    repeat (4) begin
      @(posedge clk); #1;
      check("hold_pixel", pixel_out, 20);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    feed_frame(1'b1, NPIX, 3000);
    compare_frame("hold");

    // Five requests with no input traffic: one popped, four queued.
    got.delete();
    for (int k = 0; k < 5; k++) push_req(k, k);
    @(negedge clk);
    check("q5_cfg_ready", cfg_ready, 0);
    check("q5_busy", busy, 1);
    for (int k = 0; k < 5; k++) begin
      got.delete();
      exp_id = (exp_id + 1) % 256;
      build_exp(k, k, exp_id);
      idx = 0;
      feed_frame(k[0], NPIX, 3000);
      compare_frame($sformatf("q5_f%0d", k));
    end
    check("q5_idle_after", busy, 0);

    // Randomized requests (some invalid) with random valid/ready traffic.
    for (int k = 0; k < 8; k++) begin
      int y, x;
      bit bad;
      string tag = $sformatf("rnd%0d", k);
      got.delete();
      bad = ($urandom_range(0, 3) == 0);
      if (bad && $urandom_range(0, 1) == 1) begin
        y = $urandom_range(IR - OR_ + 1, 15);
        x = $urandom_range(0, 15);
      end else if (bad) begin
        y = $urandom_range(0, IR - OR_);
        x = $urandom_range(IC - OC + 1, 15);
      end else begin
        y = $urandom_range(0, IR - OR_);
        x = $urandom_range(0, IC - OC);
      end
      push_req(y, x);
      if (bad) begin
        check_bad_req(tag);
      end else begin
        check({tag, "_no_err"}, err_bad_cfg, 0);
        exp_id = (exp_id + 1) % 256;
        build_exp(y, x, exp_id);
        idx = 0;
        feed_frame(1'b1, NPIX, 3000);
        compare_frame(tag);
      end
    end

    // Reset in the middle of a frame, then a fresh request.
    got.delete();
    push_req(2, 2);
    idx = 0;
    feed_frame(1'b0, 30, 500);
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_cfg_ready", cfg_ready, 1);
    got.delete();
    exp_id = 1;
    build_exp(0, 0, exp_id);
    push_req(0, 0);
    idx = 0;
    feed_frame(1'b0, NPIX, 2000);
    compare_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
